mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised successor to the pipeline memory stage. It owns every data-cache transaction for one instruction: word/byte loads and stores, and LDI/STI double indirection. It talks to the data cache over a request/response handshake and stalls the pipeline until the access completes. It sits between execute and writeback, and also selects the next PC (JMP/JSR, BR, or TRAP vector from memory).

## Interface
Parameters:
- LINE_BITS, 128, data-cache line width; power of two, ≥ 32
- ADDR_BITS, 16, address width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  instruction in stage is valid; held stable by upstream while stall=1
- mem_op  in  lc3b_mem_op  NONE, LDW, LDB, STW, STB, LDI, STI
- addr_in  in  ADDR_BITS  effective address (ALU result)
- wdata_in  in  16  store data (source register)
- pc_br, pc_j  in  16 each  branch target, jump target
- newpc_sel  in  2  0 selects pc_j, 1 selects pc_br, 2 and 3 select load_data
- dmem_resp  in  1  cache completes the current request
- dmem_rdata  in  LINE_BITS  line read data
- dmem_read, dmem_write  out  1 each  request strobes
- dmem_address  out  ADDR_BITS  request address
- dmem_wdata  out  LINE_BITS  store word replicated across the line
- dmem_byte_enable  out  LINE_BITS/8  write byte mask
- stall  out  1  freeze upstream stages
- done  out  1  one-cycle pulse: access complete
- load_data  out  16  registered load result
- pc_out  out  16  next-PC mux output

## Operation
FSM states: IDLE, PTR, ACC, DONE.

- IDLE:
  - valid_in & mem_op≠NONE: latch op, addr_in, wdata_in.
  - Go to PTR for LDI/STI, otherwise ACC.
  - stall is asserted combinationally in this cycle.
- PTR: dmem_read=1, dmem_address = latched address with bit0 forced to 0. On dmem_resp, replace the latched address with the selected word, then go to ACC.
- ACC:
  - Loads: dmem_read=1.
  - Stores: dmem_write=1.
  - On dmem_resp: load_data ← selected word (LDW/LDI) or selected byte zero-extended (LDB), then go to DONE. Stores leave load_data unchanged.
- DONE: done=1, stall=0, return to IDLE. The pipeline advances this cycle.
- Word select: line bits [16·w +: 16] with w = addr[log2(LINE_BITS/8)-1:1]. Byte select uses addr[0] within that word.
- Byte enables:
  - STW/STI: bits 2w and 2w+1.
  - STB: bit addr[log2(LINE_BITS/8)-1:0] only.
  - Mask is zero whenever dmem_write=0.
- Word accesses ignore address bit0; there is no misalignment trap.
- stall = (IDLE & valid_in & mem_op≠NONE) | PTR | ACC.
- pc_out is combinational from newpc_sel.

## Timing
- Reset value of every output: 0.
  - This includes load_data, done and all strobes.
  - pc_out follows its mux inputs combinationally and is 0 only if they are 0.
- Reset asserted mid-access: return to IDLE immediately and drop strobes. The cache must tolerate a dropped request.
- dmem_resp may assert in the same cycle a strobe rises. Minimum latency in cycles (accept to done):
  - LDW/LDB/STW/STB: 2
  - LDI/STI: 3
- Each extra wait cycle of dmem_resp adds one cycle; strobes and address stay stable while waiting.
- dmem_resp in IDLE or DONE is ignored.
- A mem_op=NONE instruction never stalls.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle after DONE.

## Configuration
- MEM_STAGE_INDIRECT_EN defined: LDI/STI use the PTR state as above.
- Undefined: the PTR state is not compiled. LDI and STI behave exactly as LDW and STW (single access).

## Structure
- lc3b_types gains the lc3b_mem_op enum and a mem_stage_state_t enum.
- One sub-module: line_word_select, parametrised on LINE_BITS. It takes the line and address and returns the 16-bit word and the zero-extended byte. It is shared by the PTR and ACC paths.

## Test plan
- LDW, addr 0x1236, line word 3 = 0xBEEF, resp in the same cycle as read → done in cycle 2, load_data=0xBEEF, dmem_address=0x1236.
- STB, addr 0x1009, wdata 0x00AB, LINE_BITS=128 → dmem_byte_enable=0x0200, dmem_write for 1 cycle, stall falls with done.
- LDI, pointer word 0x4000, then 0x4000 holds 0x1234, resp after 2 wait cycles each → two read phases, load_data=0x1234, done at cycle 7. Without MEM_STAGE_INDIRECT_EN: a single read and load_data = pointer word.
- LDB, addr 0x0003, byte 0x80 → load_data=0x0080 (zero-extended).
- rst_n pulsed low during ACC → strobes, stall and done drop asynchronously, FSM returns to IDLE, and the next LDW completes normally.
- LINE_BITS=256, STW, addr 0x001E → byte_enable bits 30 and 31 only. newpc_sel=2 after a load → pc_out=load_data.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline memory stage.
package lc3b_types;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        LDW  = 3'd1,
        LDB  = 3'd2,
        STW  = 3'd3,
        STB  = 3'd4,
        LDI  = 3'd5,
        STI  = 3'd6
    } lc3b_mem_op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mem_stage_state_t;

    function automatic logic is_load(lc3b_mem_op op);
        return (op == LDW) || (op == LDB) || (op == LDI);
    endfunction

    function automatic logic is_store(lc3b_mem_op op);
        return (op == STW) || (op == STB) || (op == STI);
    endfunction

endpackage

// File: rtl/line_word_select.sv
// Picks the addressed 16-bit word and zero-extended byte from a cache line.
module line_word_select #(
    parameter int LINE_BITS = 128
) (
    input  logic [LINE_BITS-1:0]             i_line,
    input  logic [$clog2(LINE_BITS/8)-1:0]   i_addr,
    output logic [15:0]                      o_word,
    output logic [15:0]                      o_byte
);
    localparam int OFFB = $clog2(LINE_BITS/8);

    logic [OFFB-2:0] w_idx;

    assign w_idx  = i_addr[OFFB-1:1];
    assign o_word = i_line[16*w_idx +: 16];
    assign o_byte = i_addr[0] ? {8'h00, o_word[15:8]}
                              : {8'h00, o_word[7:0]};
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: loads, stores, indirect access, next-PC select.
// Define MEM_STAGE_INDIRECT_EN to give LDI/STI a pointer-fetch phase.
module mem_access_stage
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  lc3b_mem_op             mem_op,
    input  logic [ADDR_BITS-1:0]   addr_in,
    input  logic [15:0]            wdata_in,
    input  logic [15:0]            pc_br,
    input  logic [15:0]            pc_j,
    input  logic [1:0]             newpc_sel,
    input  logic                   dmem_resp,
    input  logic [LINE_BITS-1:0]   dmem_rdata,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic [ADDR_BITS-1:0]   dmem_address,
    output logic [LINE_BITS-1:0]   dmem_wdata,
    output logic [LINE_BITS/8-1:0] dmem_byte_enable,
    output logic                   stall,
    output logic                   done,
    output logic [15:0]            load_data,
    output logic [15:0]            pc_out
);
    localparam int OFFB = $clog2(LINE_BITS/8);

    mem_stage_state_t r_state;
    mem_stage_state_t w_next;
    lc3b_mem_op       r_op;
    logic [ADDR_BITS-1:0] r_addr;
    logic [15:0]      r_wdata;
    logic [15:0]      r_load_data;
    logic [15:0]      w_word;
    logic [15:0]      w_byte;
    logic [15:0]      w_st_word;
    logic             w_accept;
    logic             w_indirect;

    assign w_accept = valid_in && (mem_op != NONE);

`ifdef MEM_STAGE_INDIRECT_EN
    assign w_indirect = (mem_op == LDI) || (mem_op == STI);
`else
    assign w_indirect = 1'b0;
`endif

    line_word_select #(
        .LINE_BITS (LINE_BITS)
    ) u_sel (
        .i_line (dmem_rdata),
        .i_addr (r_addr[OFFB-1:0]),
        .o_word (w_word),
        .o_byte (w_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_accept) begin
                r_op    <= mem_op;
                r_addr  <= addr_in;
                r_wdata <= wdata_in;
            end
`ifdef MEM_STAGE_INDIRECT_EN
            if (r_state == PTR && dmem_resp)
                r_addr <= ADDR_BITS'(w_word);
`endif
            if (r_state == ACC && dmem_resp && is_load(r_op))
                r_load_data <= (r_op == LDB) ? w_byte : w_word;
        end
    end

    always_comb begin
        w_next       = r_state;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = r_addr;
        stall        = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Gated so stall reads 0 while reset is held.
                    stall  = rst_n;
                    w_next = w_indirect ? PTR : ACC;
                end
            end
`ifdef MEM_STAGE_INDIRECT_EN
            PTR: begin
                dmem_read    = 1'b1;
                dmem_address = {r_addr[ADDR_BITS-1:1], 1'b0};
                stall        = 1'b1;
                if (dmem_resp)
                    w_next = ACC;
            end
`endif
            ACC: begin
                dmem_read  = is_load(r_op);
                dmem_write = is_store(r_op);
                stall      = 1'b1;
                if (dmem_resp)
                    w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Byte stores duplicate the byte so either lane of the word carries it.
    assign w_st_word  = (r_op == STB) ? {2{r_wdata[7:0]}} : r_wdata;
    assign dmem_wdata = {(LINE_BITS/16){w_st_word}};

    always_comb begin
        dmem_byte_enable = '0;
        if (dmem_write) begin
            if (r_op == STB) begin
                dmem_byte_enable[r_addr[OFFB-1:0]] = 1'b1;
            end else begin
                dmem_byte_enable[{r_addr[OFFB-1:1], 1'b0}] = 1'b1;
                dmem_byte_enable[{r_addr[OFFB-1:1], 1'b1}] = 1'b1;
            end
        end
    end

    assign load_data = r_load_data;

    always_comb begin
        pc_out = load_data;
        unique case (newpc_sel)
            2'd0:    pc_out = pc_j;
            2'd1:    pc_out = pc_br;
            default: pc_out = load_data;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small data-cache responder.
module tb_mem_access_stage;
    import lc3b_types::*;

    localparam int LB = 128;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    lc3b_mem_op      mem_op;
    logic [15:0]     addr_in;
    logic [15:0]     wdata_in;
    logic [15:0]     pc_br;
    logic [15:0]     pc_j;
    logic [1:0]      newpc_sel;
    logic            dmem_resp;
    logic [LB-1:0]   dmem_rdata;
    logic            dmem_read;
    logic            dmem_write;
    logic [15:0]     dmem_address;
    logic [LB-1:0]   dmem_wdata;
    logic [LB/8-1:0] dmem_byte_enable;
    logic            stall;
    logic            done;
    logic [15:0]     load_data;
    logic [15:0]     pc_out;

    logic            v2;
    lc3b_mem_op      op2;
    logic [15:0]     a2;
    logic            resp2;
    logic [255:0]    rdata2;
    logic            rd2;
    logic            wr2;
    logic [15:0]     addr2;
    logic [255:0]    wd2;
    logic [31:0]     be2;
    logic            stall2;
    logic            done2;
    logic [15:0]     ld2;
    logic [15:0]     pc2;

    always #5 clk = ~clk;

    mem_access_stage #(.LINE_BITS(LB), .ADDR_BITS(16)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .mem_op           (mem_op),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .pc_br            (pc_br),
        .pc_j             (pc_j),
        .newpc_sel        (newpc_sel),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .done             (done),
        .load_data        (load_data),
        .pc_out           (pc_out)
    );

    mem_access_stage #(.LINE_BITS(256), .ADDR_BITS(16)) u_dut256 (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (v2),
        .mem_op           (op2),
        .addr_in          (a2),
        .wdata_in         (16'h5A5A),
        .pc_br            (16'h0000),
        .pc_j             (16'h0000),
        .newpc_sel        (2'd0),
        .dmem_resp        (resp2),
        .dmem_rdata       (rdata2),
        .dmem_read        (rd2),
        .dmem_write       (wr2),
        .dmem_address     (addr2),
        .dmem_wdata       (wd2),
        .dmem_byte_enable (be2),
        .stall            (stall2),
        .done             (done2),
        .load_data        (ld2),
        .pc_out           (pc2)
    );

    // Cache model: lines keyed by address[15:4], fixed wait per phase.
    logic [LB-1:0] mem [int];
    int            wait_cfg = 0;
    int            wcnt = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    logic [15:0]   last_raddr = '0;
    logic [15:0]   last_waddr = '0;
    logic [15:0]   last_be = '0;
    logic [LB-1:0] last_wdata = '0;

    initial begin
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
    end

    always @(negedge clk) begin
        if (rst_n && (dmem_read || dmem_write)) begin
            if (dmem_write) begin
                wr_cnt++;
                last_be    = dmem_byte_enable;
                last_wdata = dmem_wdata;
                last_waddr = dmem_address;
            end
            if (wcnt >= wait_cfg) begin
                dmem_resp = 1'b1;
                wcnt      = 0;
                if (mem.exists(int'(dmem_address[15:4])))
                    dmem_rdata = mem[int'(dmem_address[15:4])];
                else
                    dmem_rdata = '0;
                if (dmem_read) begin
                    rd_cnt++;
                    last_raddr = dmem_address;
                end
            end else begin
                dmem_resp = 1'b0;
                wcnt++;
            end
        end else begin
            dmem_resp = 1'b0;
            wcnt      = 0;
        end
    end

    typedef struct {
        string       tag;
        logic [15:0] ld;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input lc3b_mem_op op,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int wt, input logic [15:0] exp_ld,
                          input int exp_lat);
        int   cyc;
        exp_t e;
        wait_cfg = wt;
        @(negedge clk);
        valid_in = 1'b1;
        mem_op   = op;
        addr_in  = a;
        wdata_in = wd;
        sb.push_back('{tag, exp_ld, exp_lat});
        #1 chk({tag, "_stall_acc"}, 256'(stall), 256'(1));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        e = sb.pop_front();
        chk({e.tag, "_lat"}, 256'(cyc), 256'(e.lat));
        chk({e.tag, "_ld"}, 256'(load_data), 256'(e.ld));
        chk({e.tag, "_stall_done"}, 256'(stall), 256'(0));
        valid_in = 1'b0;
        mem_op   = NONE;
    endtask

    initial begin
        logic [LB-1:0] ln;
        int            r0;
        int            w0;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        mem_op    = NONE;
        addr_in   = '0;
        wdata_in  = '0;
        pc_br     = '0;
        pc_j      = '0;
        newpc_sel = 2'd0;
        v2        = 1'b0;
        op2       = NONE;
        a2        = '0;
        resp2     = 1'b0;
        rdata2    = '0;

        ln = '0;
        ln[48 +: 16] = 16'hBEEF;
        ln[32 +: 16] = 16'h1111;
        mem[32'h123] = ln;
        ln = '0;
        ln[15:0] = 16'h4000;
        mem[32'h200] = ln;
        ln = '0;
        ln[15:0] = 16'h1234;
        mem[32'h400] = ln;
        ln = '0;
        ln[16 +: 16] = 16'h8011;
        mem[0] = ln;

        repeat (2) @(negedge clk);
        chk("rst_read", 256'(dmem_read), 256'(0));
        chk("rst_write", 256'(dmem_write), 256'(0));
        chk("rst_addr", 256'(dmem_address), 256'(0));
        chk("rst_be", 256'(dmem_byte_enable), 256'(0));
        chk("rst_wdata", 256'(dmem_wdata), 256'(0));
        chk("rst_stall", 256'(stall), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_ld", 256'(load_data), 256'(0));
        chk("rst_pc", 256'(pc_out), 256'(0));
        rst_n = 1'b1;

        r0 = rd_cnt;
        run_op("ldw", LDW, 16'h1236, 16'h0, 0, 16'hBEEF, 2);
        chk("ldw_raddr", 256'(last_raddr), 256'(16'h1236));
        chk("ldw_reads", 256'(rd_cnt - r0), 256'(1));

        w0 = wr_cnt;
        run_op("stb", STB, 16'h1009, 16'h00AB, 0, 16'hBEEF, 2);
        chk("stb_be", 256'(last_be), 256'(16'h0200));
        chk("stb_wcyc", 256'(wr_cnt - w0), 256'(1));
        chk("stb_lane", 256'(last_wdata[72 +: 8]), 256'(8'hAB));
        chk("stb_waddr", 256'(last_waddr), 256'(16'h1009));

        run_op("stw", STW, 16'h1236, 16'hCAFE, 0, 16'hBEEF, 2);
        chk("stw_be", 256'(last_be), 256'(16'h00C0));
        chk("stw_wdata", 256'(last_wdata), 256'({8{16'hCAFE}}));

        r0 = rd_cnt;
`ifdef MEM_STAGE_INDIRECT_EN
        run_op("ldi", LDI, 16'h2000, 16'h0, 2, 16'h1234, 7);
        chk("ldi_reads", 256'(rd_cnt - r0), 256'(2));
        chk("ldi_raddr", 256'(last_raddr), 256'(16'h4000));
`else
        run_op("ldi", LDI, 16'h2000, 16'h0, 2, 16'h4000, 4);
        chk("ldi_reads", 256'(rd_cnt - r0), 256'(1));
        chk("ldi_raddr", 256'(last_raddr), 256'(16'h2000));
`endif

        run_op("ldb", LDB, 16'h0003, 16'h0, 0, 16'h0080, 2);

        pc_j  = 16'h1111;
        pc_br = 16'h2222;
        newpc_sel = 2'd0;
        #1 chk("pc_j", 256'(pc_out), 256'(16'h1111));
        newpc_sel = 2'd1;
        #1 chk("pc_br", 256'(pc_out), 256'(16'h2222));
        newpc_sel = 2'd2;
        #1 chk("pc_ld2", 256'(pc_out), 256'(16'h0080));
        newpc_sel = 2'd3;
        #1 chk("pc_ld3", 256'(pc_out), 256'(16'h0080));

        @(negedge clk);
        valid_in = 1'b1;
        mem_op   = NONE;
        #1 chk("none_stall", 256'(stall), 256'(0));
        @(negedge clk);
        chk("none_stall2", 256'(stall), 256'(0));
        chk("none_read", 256'(dmem_read), 256'(0));
        valid_in = 1'b0;

        wait_cfg = 10;
        @(negedge clk);
        valid_in = 1'b1;
        mem_op   = LDW;
        addr_in  = 16'h1234;
        repeat (2) @(negedge clk);
        chk("mid_read", 256'(dmem_read), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_read", 256'(dmem_read), 256'(0));
        chk("mid_rst_stall", 256'(stall), 256'(0));
        chk("mid_rst_done", 256'(done), 256'(0));
        chk("mid_rst_ld", 256'(load_data), 256'(0));
        valid_in = 1'b0;
        mem_op   = NONE;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", LDW, 16'h1236, 16'h0, 0, 16'hBEEF, 2);

        run_op("b2b_a", LDB, 16'h1237, 16'h0, 1, 16'h00BE, 3);
        run_op("b2b_b", LDW, 16'h1234, 16'h0, 0, 16'h1111, 2);

        @(negedge clk);
        v2  = 1'b1;
        op2 = STW;
        a2  = 16'h001E;
        @(negedge clk);
        chk("w256_write", 256'(wr2), 256'(1));
        chk("w256_be", 256'(be2), 256'(32'hC000_0000));
        resp2 = 1'b1;
        @(negedge clk);
        chk("w256_done", 256'(done2), 256'(1));
        v2    = 1'b0;
        op2   = NONE;
        resp2 = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
